// File: rtl/ram_bist_pkg.sv
// Shared types and the expected-data generator for the RAM BIST engine.
// The generator works on a fixed 32-bit width so any DATA_W up to 32 can use it.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR,
    PAT_INV,
    PAT_CHECKER,
    PAT_WALK1
  } pattern_e;

  localparam int unsigned EXP_W = 32;

  function automatic logic [EXP_W-1:0] exp_data(input logic [EXP_W-1:0] addr,
                                                input pattern_e pat,
                                                input int unsigned data_w);
    logic [EXP_W-1:0] mask;
    logic [EXP_W-1:0] val;
    mask = (data_w >= EXP_W) ? '1 : ((EXP_W'(1) << data_w) - EXP_W'(1));
    case (pat)
      PAT_ADDR:    val = addr;
      PAT_INV:     val = ~addr;
      PAT_CHECKER: val = addr[0] ? {(EXP_W/2){2'b10}} : {(EXP_W/2){2'b01}};
      default:     val = EXP_W'(1) << (addr % EXP_W'(data_w));
    endcase
    return val & mask;
  endfunction

endpackage

// File: rtl/ram_bist_cmp_pipe.sv
// Delays {valid, addr, expected} by the RAM read latency and compares with q.
// Keeps a saturating mismatch count and the address of the first mismatch.
module ram_bist_cmp_pipe
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] q_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [ADDR_W-1:0]       addrPipe_q [READ_LATENCY];
  logic [DATA_W-1:0]       expPipe_q  [READ_LATENCY];
  logic [ERR_W-1:0]        err_q;
  logic [ADDR_W-1:0]       fail_q;
  logic                    seen_q;
  logic                    mismatch;

  assign mismatch = valid_q[READ_LATENCY-1] && (q_i != expPipe_q[READ_LATENCY-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        addrPipe_q[i] <= '0;
        expPipe_q[i]  <= '0;
      end
      err_q  <= '0;
      fail_q <= '0;
      seen_q <= 1'b0;
    end else begin
      valid_q[0]    <= valid_i;
      addrPipe_q[0] <= addr_i;
      expPipe_q[0]  <= exp_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i]    <= valid_q[i-1];
        addrPipe_q[i] <= addrPipe_q[i-1];
        expPipe_q[i]  <= expPipe_q[i-1];
      end
      if (clear_i) begin
        err_q  <= '0;
        fail_q <= '0;
        seen_q <= 1'b0;
      end else if (mismatch) begin
        if (err_q != '1) begin
          err_q <= err_q + 1'b1;
        end
        if (!seen_q) begin
          fail_q <= addrPipe_q[READ_LATENCY-1];
          seen_q <= 1'b1;
        end
      end
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = fail_q;

endmodule

// File: rtl/ram_bist_controller.sv
// Write-all / read-all / compare BIST engine for a single-port synchronous RAM.
// Write, read and control outputs are registered so the RAM sees clean signals.
module ram_bist_controller
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic              w,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int unsigned DRAIN_W = 2;

  state_e             state_q, state_d;
  pattern_e           pat_q, pat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  writeAddr_q, writeAddr_d;
  logic [ADDR_W-1:0]  readAddr_q, readAddr_d;
  logic               w_q, w_d;
  logic               pass_q, pass_d;
  logic               cmpClear;
  logic               rdValid;
  logic [DATA_W-1:0]  rdExp;
  logic               addrLast;

  function automatic logic [DATA_W-1:0] patData(input logic [ADDR_W-1:0] a, input pattern_e p);
    logic [EXP_W-1:0] full;
    full = exp_data(EXP_W'(a), p, DATA_W);
    return full[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= PAT_ADDR;
      addr_q      <= '0;
      drainCnt_q  <= '0;
      data_q      <= '0;
      writeAddr_q <= '0;
      readAddr_q  <= '0;
      w_q         <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      addr_q      <= addr_d;
      drainCnt_q  <= drainCnt_d;
      data_q      <= data_d;
      writeAddr_q <= writeAddr_d;
      readAddr_q  <= readAddr_d;
      w_q         <= w_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    addr_d      = addr_q;
    drainCnt_d  = drainCnt_q;
    data_d      = data_q;
    writeAddr_d = writeAddr_q;
    readAddr_d  = readAddr_q;
    w_d         = 1'b0;
    pass_d      = pass_q;
    cmpClear    = 1'b0;
    rdValid     = 1'b0;
    rdExp       = patData(addr_q, pat_q);
    addrLast    = (addr_q == '1);

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d       = pattern_e'(pattern);
          state_d     = WRITE;
          addr_d      = '0;
          w_d         = 1'b1;
          writeAddr_d = '0;
          data_d      = patData('0, pattern_e'(pattern));
          cmpClear    = 1'b1;
          pass_d      = 1'b0;
        end
      end
      WRITE: begin
        if (addrLast) begin
          state_d    = READ;
          addr_d     = '0;
          readAddr_d = '0;
        end else begin
          addr_d      = addr_q + 1'b1;
          w_d         = 1'b1;
          writeAddr_d = addr_q + 1'b1;
          data_d      = patData(addr_q + 1'b1, pat_q);
        end
      end
      READ: begin
        rdValid = 1'b1;
        if (addrLast) begin
          state_d    = DRAIN;
          drainCnt_d = DRAIN_W'(READ_LATENCY);
        end else begin
          addr_d     = addr_q + 1'b1;
          readAddr_d = addr_q + 1'b1;
        end
      end
      // Counting down from READ_LATENCY to zero gives one cycle beyond the pipe
      // depth, so the last compare has landed in err_count before pass samples it.
      DRAIN: begin
        if (drainCnt_q == '0) begin
          state_d = DONE;
          pass_d  = (err_count == '0);
        end else begin
          drainCnt_d = drainCnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ram_bist_cmp_pipe #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .READ_LATENCY(READ_LATENCY),
    .ERR_W       (ERR_W)
  ) u_cmp_pipe (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cmpClear),
    .valid_i    (rdValid),
    .addr_i     (addr_q),
    .exp_i      (rdExp),
    .q_i        (q),
    .err_count_o(err_count),
    .fail_addr_o(fail_addr)
  );

  assign data       = data_q;
  assign write_addr = writeAddr_q;
  assign read_addr  = readAddr_q;
  assign w          = w_q;
  assign pass       = pass_q;
  assign busy       = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_ram_bist_controller.sv
// Bench for ram_bist_controller: behavioural RAM with injectable faults, a table of
// directed runs, randomized runs against a pattern/fault model, and corner sequences.
module tb_ram_bist_controller;

  localparam int DEPTH    = 64;
  localparam int LAT      = 1;
  localparam int DONE_LAT = 2 * DEPTH + LAT + 1;
  localparam int F_NONE   = 0;
  localparam int F_FLIP   = 1;
  localparam int F_STUCK0 = 2;
  localparam int F_INV    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [1:0] pattern, pattern2;
  logic [7:0] data, data2, q, q2;
  logic [5:0] write_addr, write_addr2, read_addr, read_addr2;
  logic       w, w2, busy, busy2, done, done2, pass, pass2;
  logic [7:0] err_count;
  logic [3:0] err_count2;
  logic [5:0] fail_addr, fail_addr2;

  int checks = 0;
  int failures = 0;
  int faultMode = F_NONE;
  int faultAddr = 0;
  int faultBit = 0;
  int wOutside = 0;
  int busyAfterStart = 0;
  int wrAddrQ[$];
  int wrDataQ[$];

  always #5 clk = ~clk;

  ram_bist_controller #(.DATA_W(8), .ADDR_W(6), .READ_LATENCY(LAT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .data(data),
    .write_addr(write_addr), .read_addr(read_addr), .w(w), .q(q), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
  );

  ram_bist_controller #(.DATA_W(8), .ADDR_W(6), .READ_LATENCY(LAT), .ERR_W(4)) dutSat (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern2), .data(data2),
    .write_addr(write_addr2), .read_addr(read_addr2), .w(w2), .q(q2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err_count2), .fail_addr(fail_addr2)
  );

  function automatic logic [7:0] refExp(int a, int p);
    case (p)
      0:       return 8'(a);
      1:       return 8'(255 - a);
      2:       return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return 8'(1 << (a % 8));
    endcase
  endfunction

  function automatic logic [7:0] applyFault(logic [7:0] v, logic [5:0] a, int mode, int fa, int fb);
    logic [7:0] r;
    r = v;
    if (mode == F_FLIP && int'(a) == fa) r[fb] = ~r[fb];
    else if (mode == F_STUCK0) r[fb] = 1'b0;
    else if (mode == F_INV) r = ~r;
    return r;
  endfunction

  // Behavioural single-port RAMs, one read cycle of latency.
  logic [7:0] mem1 [DEPTH];
  logic [7:0] mem2 [DEPTH];
  logic [7:0] rd1, rd2;
  logic [5:0] rdAddr1;

  always @(posedge clk) begin
    if (w) mem1[write_addr] <= data;
    if (w2) mem2[write_addr2] <= data2;
    rd1     <= mem1[read_addr];
    rd2     <= mem2[read_addr2];
    rdAddr1 <= read_addr;
  end

  assign q  = applyFault(rd1, rdAddr1, faultMode, faultAddr, faultBit);
  assign q2 = ~rd2;

  always @(negedge clk) begin
    if (w) begin
      wrAddrQ.push_back(int'(write_addr));
      wrDataQ.push_back(int'(data));
    end
    if ((w && !busy) || (w2 && !busy2)) wOutside++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic computeModel(input int p, input int mode, input int fa, input int fb,
                              input int errMax, output int err, output int fail, output int ok);
    logic [7:0] e;
    err  = 0;
    fail = 0;
    for (int a = 0; a < DEPTH; a++) begin
      e = refExp(a, p);
      if (applyFault(e, 6'(a), mode, fa, fb) != e) begin
        if (err == 0) fail = a;
        if (err < errMax) err++;
      end
    end
    ok = (err == 0) ? 1 : 0;
  endtask

  task automatic applyStimulus(input int p, input int rePulseAt, output int latency);
    wrAddrQ.delete();
    wrDataQ.delete();
    wOutside = 0;
    @(negedge clk);
    pattern = 2'(p);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    latency = 0;
    while (!done && latency < 400) begin
      @(negedge clk);
      latency++;
      if (latency == 1) busyAfterStart = int'(busy);
      if (latency == rePulseAt) begin
        start   = 1'b1;
        pattern = 2'((p + 1) % 4);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkRun(input string tag, input int p, input int latency,
                          input int expErr, input int expFail, input int expPass);
    int seqErrs;
    int passAtDone;
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_latency"}, latency, DONE_LAT);
    checkOutput({tag, "_busyAfterStart"}, busyAfterStart, 1);
    checkOutput({tag, "_errCount"}, int'(err_count), expErr);
    checkOutput({tag, "_failAddr"}, int'(fail_addr), expFail);
    checkOutput({tag, "_pass"}, int'(pass), expPass);
    checkOutput({tag, "_numWrites"}, wrAddrQ.size(), DEPTH);
    seqErrs = 0;
    for (int i = 0; i < wrAddrQ.size() && i < DEPTH; i++) begin
      if (wrAddrQ[i] != i || wrDataQ[i] != int'(refExp(i, p))) seqErrs++;
    end
    checkOutput({tag, "_writeSeqErrors"}, seqErrs, 0);
    checkOutput({tag, "_wOutsideWrite"}, wOutside, 0);
    passAtDone = int'(pass);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, int'(done), 0);
    checkOutput({tag, "_busyAfterDone"}, int'(busy), 0);
    checkOutput({tag, "_passHeld"}, int'(pass), passAtDone);
  endtask

  typedef struct {
    int pat;
    int mode;
    int fa;
    int fb;
    int expErr;
    int expFail;
    int expPass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int latency;
    int mErr, mFail, mPass;
    int p, mode, fa, fb;
    int waitCnt;

    vecs[0] = '{pat: 0, mode: F_NONE,   fa: 0,  fb: 0, expErr: 0,  expFail: 0,  expPass: 1};
    vecs[1] = '{pat: 0, mode: F_FLIP,   fa: 10, fb: 3, expErr: 1,  expFail: 10, expPass: 0};
    vecs[2] = '{pat: 0, mode: F_STUCK0, fa: 0,  fb: 0, expErr: 32, expFail: 1,  expPass: 0};
    vecs[3] = '{pat: 2, mode: F_NONE,   fa: 0,  fb: 0, expErr: 0,  expFail: 0,  expPass: 1};
    vecs[4] = '{pat: 3, mode: F_NONE,   fa: 0,  fb: 0, expErr: 0,  expFail: 0,  expPass: 1};
    vecs[5] = '{pat: 1, mode: F_INV,    fa: 0,  fb: 0, expErr: 64, expFail: 0,  expPass: 0};

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    pattern = 2'd0;
    pattern2 = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_w", int'(w), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_pass", int'(pass), 0);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_writeAddr", int'(write_addr), 0);
    checkOutput("reset_readAddr", int'(read_addr), 0);
    checkOutput("reset_errCount", int'(err_count), 0);
    checkOutput("reset_failAddr", int'(fail_addr), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      faultMode = vecs[i].mode;
      faultAddr = vecs[i].fa;
      faultBit  = vecs[i].fb;
      applyStimulus(vecs[i].pat, -1, latency);
      checkRun($sformatf("vec%0d", i), vecs[i].pat, latency,
               vecs[i].expErr, vecs[i].expFail, vecs[i].expPass);
    end

    for (int i = 0; i < 6; i++) begin
      p    = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      fa   = int'($urandom_range(0, DEPTH - 1));
      fb   = int'($urandom_range(0, 7));
      faultMode = mode;
      faultAddr = fa;
      faultBit  = fb;
      computeModel(p, mode, fa, fb, 255, mErr, mFail, mPass);
      applyStimulus(p, -1, latency);
      checkRun($sformatf("rand%0d", i), p, latency, mErr, mFail, mPass);
    end

    // Start re-pulsed (with a different pattern) mid-READ must be ignored.
    faultMode = F_NONE;
    applyStimulus(3, 80, latency);
    checkRun("repulse", 3, latency, 0, 0, 1);

    // Reset mid-WRITE, then a clean rerun.
    faultMode = F_STUCK0;
    faultBit  = 0;
    applyStimulus(0, -1, latency);
    checkOutput("preRst_pass", int'(pass), 0);
    @(negedge clk);
    pattern = 2'd0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    waitCnt = 0;
    while (!(w && write_addr == 6'd20) && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rst_reachedAddr20", int'(write_addr), 20);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_w", int'(w), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_data", int'(data), 0);
    checkOutput("rst_writeAddr", int'(write_addr), 0);
    checkOutput("rst_readAddr", int'(read_addr), 0);
    checkOutput("rst_errCount", int'(err_count), 0);
    checkOutput("rst_failAddr", int'(fail_addr), 0);
    checkOutput("rst_pass", int'(pass), 0);
    rst = 1'b0;
    faultMode = F_NONE;
    applyStimulus(0, -1, latency);
    checkRun("afterRst", 0, latency, 0, 0, 1);

    // Every read inverted on the 4-bit-counter instance: counter saturates at 15.
    @(negedge clk);
    pattern2 = 2'($urandom_range(0, 3));
    start2   = 1'b1;
    @(negedge clk);
    start2   = 1'b0;
    latency  = 0;
    while (!done2 && latency < 400) begin
      @(negedge clk);
      latency++;
    end
    checkOutput("sat_done", int'(done2), 1);
    checkOutput("sat_latency", latency, DONE_LAT);
    checkOutput("sat_errCount", int'(err_count2), 15);
    checkOutput("sat_failAddr", int'(fail_addr2), 0);
    checkOutput("sat_pass", int'(pass2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
